tour_move_sequencer: RTL and testbench
======================================

Name: tour_move_sequencer

Overview:
- Command-source controller between the UART command path, the tour solver's move memory, and the command processor.
- Idle: passes UART commands straight through to the command processor.
- On start_tour: takes over the command interface and replays the solved tour.
  - Each knight move is split into a vertical leg command, then a horizontal leg command.
  - Each leg waits for the command processor's send_resp before the next leg starts.
- Also selects the response byte returned over UART.

Parameters:
- NUM_MOVES, 24: tour length, i.e. the number of L-moves replayed, indices 0..NUM_MOVES-1.
- IDX_W, 5: width of mv_indx; must satisfy 2**IDX_W >= NUM_MOVES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_UART  input  16  command from UART wrapper
- cmd_rdy_UART  input  1  UART command valid
- clr_cmd_rdy_UART  output  1  one-cycle pulse consuming the UART command
- start_tour  input  1  one-cycle pulse from solver: solution ready
- move  input  8  one-hot move at mv_indx, from solver memory, combinational read
- mv_indx  output  IDX_W  move memory read index
- cmd  output  16  command to command processor
- cmd_rdy  output  1  command valid to command processor
- clr_cmd_rdy  input  1  command processor consumed cmd
- send_resp  input  1  command processor finished a command
- resp  output  8  response byte for UART
- tour_busy  output  1  high while the sequencer owns the command interface

Behaviour:
- Reset values: state IDLE, mv_indx=0, tour_busy=0, clr_cmd_rdy_UART=0; cmd/cmd_rdy/resp follow IDLE muxing.
- IDLE (pass-through): cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
- start_tour in IDLE:
  - mv_indx<=0, tour_busy<=1, go to VERT next cycle.
  - start_tour in any other state is ignored.
- In any non-IDLE state:
  - UART inputs are ignored and clr_cmd_rdy_UART=0, so a UART command stays pending in the wrapper.
  - resp=8'h5A, except in the final HOLD_HORZ (mv_indx==NUM_MOVES-1), where resp=8'hA5.
- Move decode, bit -> (dx,dy):
  - 0:(+1,+2), 1:(-1,+2), 2:(-2,+1), 3:(-2,-1)
  - 4:(-1,-2), 5:(+1,-2), 6:(+2,-1), 7:(+2,+1)
  - Multi-hot: the lowest set bit wins.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
  - Vertical leg: opcode 4'h2; heading north if dy>0, else south; squares=|dy|.
  - Horizontal leg: opcode per Optional Feature; heading east if dx>0, else west; squares=|dx|.
- State machine:
  - VERT: cmd=vertical leg, cmd_rdy=1. On clr_cmd_rdy -> HOLD_VERT.
  - HOLD_VERT: cmd_rdy=0, cmd held. On send_resp -> HORZ.
  - HORZ: cmd=horizontal leg, cmd_rdy=1. On clr_cmd_rdy -> HOLD_HORZ.
  - HOLD_HORZ: on send_resp:
    - if mv_indx==NUM_MOVES-1: -> IDLE, tour_busy<=0, mv_indx<=0;
    - else: mv_indx<=mv_indx+1, -> VERT.
- move==8'h00 sampled in VERT: abort. Go to IDLE, tour_busy<=0, mv_indx<=0, no command issued.
- clr_cmd_rdy and send_resp in the same cycle: only clr_cmd_rdy is acted on; send_resp is honoured only in HOLD states.
- cmd_rdy latency: cmd_rdy is high the cycle after entering VERT/HORZ and stays high until clr_cmd_rdy.
- rst_n asserted mid-tour: immediate return to IDLE, all outputs to reset values, the tour is not resumed.

Optional Feature:
- Macro: TOUR_FANFARE_EN.
  - Defined: horizontal-leg opcode is 4'h3 (move with fanfare), so the piezo plays at every square landing.
  - Undefined: horizontal-leg opcode is 4'h2, no fanfare.
- Vertical legs always use 4'h2.

Test Plan:
- IDLE pass-through: cmd_UART=16'h2004, cmd_rdy_UART=1, clr_cmd_rdy pulse -> cmd=16'h2004, clr_cmd_rdy_UART pulses in the same cycle, resp=8'hA5.
- start_tour, move[0]=8'h01 -> first cmd=16'h2002 (north 2); after clr_cmd_rdy+send_resp, cmd=16'h3BF1 with macro (16'h2BF1 without); resp=8'h5A during the leg.
- move=8'h08 -> cmd 16'h27F1 (south 1), then 16'h3 3F2 pattern, i.e. 16'h33F2 (west 2); mv_indx increments by 1 after the second send_resp.
- Full 24-move replay with a scripted responder -> 48 commands issued; resp=8'hA5 in the final HOLD_HORZ; tour_busy falls after the last send_resp; mv_indx back to 0.
- UART cmd_rdy_UART=1 during the tour -> clr_cmd_rdy_UART stays 0 throughout; the pending command passes through in the first IDLE cycle afterwards.
- rst_n low while in HOLD_VERT at mv_indx=5 -> cmd_rdy=0, tour_busy=0, mv_indx=0 immediately; a second start_tour while busy has no effect.

Source files
------------

// File: rtl/tour_move_sequencer.sv
// Command-source mux between the UART path and the tour replay: splits each knight move into two legs.
// Optional TOUR_FANFARE_EN: horizontal legs use the fanfare opcode 4'h3 instead of 4'h2.
module tour_move_sequencer #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] VERT      = 3'd1;
  localparam logic [2:0] HOLD_VERT = 3'd2;
  localparam logic [2:0] HORZ      = 3'd3;
  localparam logic [2:0] HOLD_HORZ = 3'd4;

  localparam logic [3:0] VERT_OP = 4'h2;
`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] HORZ_OP = 4'h3;
`else
  localparam logic [3:0] HORZ_OP = 4'h2;
`endif

  localparam logic [7:0] HEAD_NORTH = 8'h00;
  localparam logic [7:0] HEAD_WEST  = 8'h3F;
  localparam logic [7:0] HEAD_SOUTH = 8'h7F;
  localparam logic [7:0] HEAD_EAST  = 8'hBF;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  logic [2:0]       state;
  logic [15:0]      cmd_hold;
  logic [1:0]       dx_mag, dy_mag;
  logic             dx_neg, dy_neg;
  logic             move_valid;
  logic             last_move;
  logic [15:0]      vert_cmd, horz_cmd;

  assign move_valid = |move;
  assign last_move  = (mv_indx == IDX_W'(NUM_MOVES - 1));

  // Lowest set bit of the one-hot move picks the L-shape; magnitudes and signs kept separately.
  always_comb begin
    dx_mag = 2'd0;
    dy_mag = 2'd0;
    dx_neg = 1'b0;
    dy_neg = 1'b0;
    if (move[0]) begin
      dx_mag = 2'd1; dx_neg = 1'b0; dy_mag = 2'd2; dy_neg = 1'b0;
    end else if (move[1]) begin
      dx_mag = 2'd1; dx_neg = 1'b1; dy_mag = 2'd2; dy_neg = 1'b0;
    end else if (move[2]) begin
      dx_mag = 2'd2; dx_neg = 1'b1; dy_mag = 2'd1; dy_neg = 1'b0;
    end else if (move[3]) begin
      dx_mag = 2'd2; dx_neg = 1'b1; dy_mag = 2'd1; dy_neg = 1'b1;
    end else if (move[4]) begin
      dx_mag = 2'd1; dx_neg = 1'b1; dy_mag = 2'd2; dy_neg = 1'b1;
    end else if (move[5]) begin
      dx_mag = 2'd1; dx_neg = 1'b0; dy_mag = 2'd2; dy_neg = 1'b1;
    end else if (move[6]) begin
      dx_mag = 2'd2; dx_neg = 1'b0; dy_mag = 2'd1; dy_neg = 1'b1;
    end else if (move[7]) begin
      dx_mag = 2'd2; dx_neg = 1'b0; dy_mag = 2'd1; dy_neg = 1'b0;
    end
  end

  assign vert_cmd = {VERT_OP, (dy_neg ? HEAD_SOUTH : HEAD_NORTH), 2'b00, dy_mag};
  assign horz_cmd = {HORZ_OP, (dx_neg ? HEAD_WEST : HEAD_EAST), 2'b00, dx_mag};

  // cmd_hold captures the leg just accepted so the HOLD states keep presenting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mv_indx   <= '0;
      tour_busy <= 1'b0;
      cmd_hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_tour) begin
            mv_indx   <= '0;
            tour_busy <= 1'b1;
            state     <= VERT;
          end
        end
        VERT: begin
          if (!move_valid) begin
            state     <= IDLE;
            tour_busy <= 1'b0;
            mv_indx   <= '0;
          end else if (clr_cmd_rdy) begin
            cmd_hold <= vert_cmd;
            state    <= HOLD_VERT;
          end
        end
        HOLD_VERT: begin
          if (send_resp) state <= HORZ;
        end
        HORZ: begin
          if (clr_cmd_rdy) begin
            cmd_hold <= horz_cmd;
            state    <= HOLD_HORZ;
          end
        end
        HOLD_HORZ: begin
          if (send_resp) begin
            if (last_move) begin
              state     <= IDLE;
              tour_busy <= 1'b0;
              mv_indx   <= '0;
            end else begin
              mv_indx <= mv_indx + IDX_W'(1);
              state   <= VERT;
            end
          end
        end
        default: begin
          state     <= IDLE;
          tour_busy <= 1'b0;
          mv_indx   <= '0;
        end
      endcase
    end
  end

  // Outside IDLE the UART side is frozen so its pending command survives the tour.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = RESP_ACK;
    case (state)
      IDLE: ;
      VERT: begin
        cmd              = vert_cmd;
        cmd_rdy          = move_valid;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
      end
      HOLD_VERT: begin
        cmd              = cmd_hold;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
      end
      HORZ: begin
        cmd              = horz_cmd;
        cmd_rdy          = 1'b1;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
      end
      HOLD_HORZ: begin
        cmd              = cmd_hold;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = last_move ? RESP_ACK : RESP_BUSY;
      end
      default: begin
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Randomized bench for tour_move_sequencer: a scripted command-processor responder checks every leg
// against a table-driven model of the knight moves (follows TOUR_FANFARE_EN like the design).
module tb_tour_move_sequencer;

  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;
`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] HORZ_OP = 4'h3;
`else
  localparam logic [3:0] HORZ_OP = 4'h2;
`endif

  logic             clk;
  logic             rst_n;
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy_UART;
  logic             start_tour;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             send_resp;
  logic [7:0]       resp;
  logic             tour_busy;

  logic [7:0] mem [NUM_MOVES];
  int checks = 0;
  int errors = 0;
  int legCount;
  int dxTab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dyTab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  tour_move_sequencer #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp), .tour_busy(tour_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign move = mem[int'(mv_indx) % NUM_MOVES];

  function automatic int lowBit(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Leg command from the move's (dx,dy) displacement.
  function automatic logic [15:0] modelLeg(input logic [7:0] m, input bit horz);
    int d, mag;
    logic [7:0] head;
    logic [3:0] op;
    d   = horz ? dxTab[lowBit(m)] : dyTab[lowBit(m)];
    mag = (d < 0) ? -d : d;
    if (horz) begin
      op   = HORZ_OP;
      head = (d > 0) ? 8'hBF : 8'h3F;
    end else begin
      op   = 4'h2;
      head = (d > 0) ? 8'h00 : 8'h7F;
    end
    return {op, head, 4'(mag)};
  endfunction

  function automatic logic [7:0] modelHoldResp(input int idx, input bit horz);
    return (horz && idx == NUM_MOVES - 1) ? 8'hA5 : 8'h5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] c, input logic rdy, input logic clr,
                               input logic snd, input logic st);
    cmd_UART     = c;
    cmd_rdy_UART = rdy;
    clr_cmd_rdy  = clr;
    send_resp    = snd;
    start_tour   = st;
  endtask

  task automatic doLeg(input int idx, input bit horz, input bit sameCycleSend);
    int waited = 0;
    while (!cmd_rdy && waited < 8) begin
      tick();
      waited++;
    end
    checkOutput("leg_rdy", 32'(cmd_rdy), 1);
    if (cmd_rdy) legCount++;
    checkOutput("leg_cmd", cmd, modelLeg(mem[idx], horz));
    checkOutput("leg_idx", mv_indx, idx);
    checkOutput("leg_busy", 32'(tour_busy), 1);
    checkOutput("leg_resp", resp, 8'h5A);
    repeat ($urandom_range(0, 2)) begin
      tick();
      checkOutput("rdy_held", 32'(cmd_rdy), 1);
    end
    clr_cmd_rdy = 1'b1;
    send_resp   = sameCycleSend;
    #1;
    checkOutput("uart_clr_blocked", 32'(clr_cmd_rdy_UART), 0);
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    checkOutput("hold_rdy", 32'(cmd_rdy), 0);
    checkOutput("hold_cmd", cmd, modelLeg(mem[idx], horz));
    checkOutput("hold_resp", resp, modelHoldResp(idx, horz));
    if (sameCycleSend) begin
      tick();
      checkOutput("same_cycle_stays_hold", 32'(cmd_rdy), 0);
      checkOutput("same_cycle_idx", mv_indx, idx);
    end
  endtask

  task automatic doResp(input int idx, input bit pokeStart);
    repeat ($urandom_range(0, 2)) tick();
    if (pokeStart) begin
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      checkOutput("start_ignored_idx", mv_indx, idx);
      checkOutput("start_ignored_rdy", 32'(cmd_rdy), 0);
      checkOutput("start_ignored_busy", 32'(tour_busy), 1);
    end
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  task automatic runTour(input bit directed);
    legCount = 0;
    applyStimulus(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    start_tour = 1'b0;
    if (directed) checkOutput("dir_first_vert", cmd, 16'h2002);
    for (int i = 0; i < NUM_MOVES; i++) begin
      doLeg(i, 1'b0, ($urandom_range(0, 3) == 0));
      doResp(i, (i == 2));
      doLeg(i, 1'b1, 1'b0);
      if (directed && i == 0) checkOutput("dir_first_horz", cmd, {HORZ_OP, 12'hBF1});
      if (directed && i == 1) checkOutput("dir_second_horz", cmd, {HORZ_OP, 12'h3F2});
      doResp(i, 1'b0);
    end
    checkOutput("tour_cmd_count", legCount, 2 * NUM_MOVES);
    checkOutput("end_busy", 32'(tour_busy), 0);
    checkOutput("end_idx", mv_indx, 0);
    checkOutput("end_pending_cmd", cmd, cmd_UART);
    checkOutput("end_pending_rdy", 32'(cmd_rdy), 1);
    checkOutput("end_resp", resp, 8'hA5);
    clr_cmd_rdy = 1'b1;
    #1;
    checkOutput("end_uart_clr", 32'(clr_cmd_rdy_UART), 1);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] c;
    logic r, k;
    rst_n = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_MOVES; i++) mem[i] = 8'(1 << $urandom_range(0, 7));
    #1;
    checkOutput("rst_idx", mv_indx, 0);
    checkOutput("rst_busy", 32'(tour_busy), 0);
    checkOutput("rst_rdy", 32'(cmd_rdy), 0);
    checkOutput("rst_uart_clr", 32'(clr_cmd_rdy_UART), 0);
    checkOutput("rst_resp", resp, 8'hA5);
    tick();
    rst_n = 1'b1;
    tick();

    applyStimulus(16'h2004, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("idle_dir_cmd", cmd, 16'h2004);
    checkOutput("idle_dir_uart_clr", 32'(clr_cmd_rdy_UART), 1);
    checkOutput("idle_dir_resp", resp, 8'hA5);
    tick();
    for (int i = 0; i < 8; i++) begin
      c = 16'($urandom);
      r = 1'($urandom);
      k = 1'($urandom);
      applyStimulus(c, r, k, 1'b0, 1'b0);
      #1;
      checkOutput("idle_cmd", cmd, c);
      checkOutput("idle_rdy", 32'(cmd_rdy), 32'(r));
      checkOutput("idle_uart_clr", 32'(clr_cmd_rdy_UART), 32'(k));
      checkOutput("idle_busy", 32'(tour_busy), 0);
      tick();
    end
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    mem[0] = 8'h01;
    mem[1] = 8'h08;
    runTour(1'b1);
    tick();

    for (int i = 0; i < NUM_MOVES; i++) mem[i] = 8'($urandom_range(1, 255));
    runTour(1'b0);
    tick();

    for (int i = 0; i < NUM_MOVES; i++) mem[i] = 8'(1 << $urandom_range(0, 7));
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    for (int i = 0; i < 5; i++) begin
      doLeg(i, 1'b0, 1'b0);
      doResp(i, 1'b0);
      doLeg(i, 1'b1, 1'b0);
      doResp(i, 1'b0);
    end
    doLeg(5, 1'b0, 1'b0);
    checkOutput("pre_reset_idx", mv_indx, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rdy", 32'(cmd_rdy), 0);
    checkOutput("midrst_busy", 32'(tour_busy), 0);
    checkOutput("midrst_idx", mv_indx, 0);
    checkOutput("midrst_resp", resp, 8'hA5);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("no_resume_busy", 32'(tour_busy), 0);
    checkOutput("no_resume_rdy", 32'(cmd_rdy), 0);

    for (int i = 0; i < NUM_MOVES; i++) mem[i] = 8'(1 << $urandom_range(0, 7));
    mem[3] = 8'h00;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    for (int i = 0; i < 3; i++) begin
      doLeg(i, 1'b0, 1'b0);
      doResp(i, 1'b0);
      doLeg(i, 1'b1, 1'b0);
      doResp(i, 1'b0);
    end
    checkOutput("abort_idx", mv_indx, 3);
    checkOutput("abort_no_cmd", 32'(cmd_rdy), 0);
    tick();
    checkOutput("abort_busy", 32'(tour_busy), 0);
    checkOutput("abort_idx_cleared", mv_indx, 0);
    checkOutput("abort_resp", resp, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
